ldl_cdc_ring_rx_track_v1: RTL

//  Rx-domain consumer of the CDC ring's sample output. The ring delivers snapshots of a
//  tx-domain word that update at irregular intervals. This block detects every change of
//  the received word, tags it with a free-running timestamp and queues {stamp,data}

---
 rtl/ldl_cdc_track_pkg.sv | 15 +
 rtl/ldl_sync_fifo_v1.sv | 71 +++++++
 rtl/ldl_cdc_ring_rx_track_v1.sv | 80 ++++++++
 3 files changed

// File: rtl/ldl_cdc_track_pkg.sv
// Shared defaults and helpers for the CDC ring rx-side change tracker.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ldl_cdc_track_pkg;

    localparam int DEF_DEPTH   = 4;
    localparam int DEF_STAMP_W = 16;
    localparam int DEF_DROP_W  = 8;

    // Pointer width carries one extra wrap bit so full and empty differ only in the MSB.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ldl_sync_fifo_v1.sv
// Show-ahead synchronous FIFO with a registered head (no fall-through path).
// Latency: an entry written on edge N is presented on dout/valid after edge N+1.
// Backpressure: pushes are accepted when not full or when popping on the same edge.
// Ports: clk, rst (async, active-high), push/din write side, pop read side (ignored while
//        empty), dout registered head, full/empty status, level = entries stored.
module ldl_sync_fifo_v1
    import ldl_cdc_track_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic             r_vld;
    logic [WIDTH-1:0] r_dout;

    logic             w_pop;
    logic             w_full;
    logic             w_wr_en;
    logic [PW-1:0]    w_rd_nxt;
    logic             w_head_avail;

    assign w_pop    = pop & r_vld;
    assign w_full   = (r_wr[PW-1] != r_rd[PW-1]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_wr_en  = push & (~w_full | w_pop);
    assign w_rd_nxt = r_rd + PW'(w_pop);
    // Only entries already in memory before this edge may become the head; this is what
    // removes the fall-through path and adds the extra cycle of latency.
    assign w_head_avail = (r_wr != w_rd_nxt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_vld  <= 1'b0;
            r_dout <= '0;
        end else begin
            if (w_wr_en) r_wr <= r_wr + PW'(1);
            if (w_pop)   r_rd <= w_rd_nxt;
            r_vld <= w_head_avail;
            // Hold the last head while nothing is available.
            if (w_head_avail) r_dout <= r_mem[w_rd_nxt[AW-1:0]];
        end
    end

    // Storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr[AW-1:0]] <= din;
    end

    assign dout  = r_dout;
    assign full  = w_full;
    assign empty = ~r_vld;
    assign level = r_wr - r_rd;

endmodule

// File: rtl/ldl_cdc_ring_rx_track_v1.sv
// Detects changes in the CDC ring's rx sample, stamps them and queues {stamp,data} events.
// Latency: value sampled on edge E0 is pushed on E1 and visible on out_* after E2.
// Backpressure: valid/ready; events arriving while full (and not popping) are dropped and counted.
// Ports: clk, rst (async, active-high), samp_in ring output, out_valid/out_ready/out_data/
//        out_stamp event stream, level FIFO occupancy, drop_cnt saturating overflow count.
module ldl_cdc_ring_rx_track_v1
    import ldl_cdc_track_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = DEF_DEPTH,
    parameter int               STAMP_W = DEF_STAMP_W,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               DROP_W  = DEF_DROP_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       samp_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [STAMP_W-1:0]     out_stamp,
    output logic [$clog2(DEPTH):0] level,
    output logic [DROP_W-1:0]      drop_cnt
);

    localparam int EW = STAMP_W + WIDTH;

    logic [WIDTH-1:0]   r_samp_q;
    logic [WIDTH-1:0]   r_ref;
    logic [STAMP_W-1:0] r_stamp;
    logic [DROP_W-1:0]  r_drop;

    logic               w_chg;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_drop;
    logic [EW-1:0]      w_dout;

    assign w_chg  = (r_samp_q != r_ref);
    assign w_pop  = ~w_empty & out_ready;
    assign w_drop = w_chg & w_full & ~w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_samp_q <= RST_VAL;
            r_ref    <= RST_VAL;
            r_stamp  <= '0;
            r_drop   <= '0;
        end else begin
            r_samp_q <= samp_in;
            r_stamp  <= r_stamp + STAMP_W'(1);
            // Reference tracks every change, even a dropped one, so a lost event is not
            // re-raised on the following cycle.
            if (w_chg) r_ref <= r_samp_q;
            if (w_drop && (r_drop != {DROP_W{1'b1}})) r_drop <= r_drop + DROP_W'(1);
        end
    end

    ldl_sync_fifo_v1 #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_chg),
        .din   ({r_stamp, r_samp_q}),
        .pop   (out_ready),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .level (level)
    );

    assign out_valid = ~w_empty;
    assign out_data  = w_dout[WIDTH-1:0];
    assign out_stamp = w_dout[EW-1:WIDTH];
    assign drop_cnt  = r_drop;

endmodule
